// File: rtl/pkg_8088.sv
// Shared definitions for the 8088-style prefetch queue: fetch FSM states,
// queue depth and segment:offset -> physical address translation.
package pkg_8088;

  localparam int PQ_DEPTH = 4;
  localparam int PQ_PW    = $clog2(PQ_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } pq_state_t;

  // Real-mode translation; the carry out of bit 19 is dropped (1 MB wrap).
  function automatic logic [19:0] phys_addr(input logic [15:0] seg,
                                            input logic [15:0] off);
    return {seg, 4'h0} + {4'h0, off};
  endfunction

endpackage

// File: rtl/prefetch_queue_if.sv
// Instruction-fetch memory bus: address/request out, ack/data back.
interface prefetch_queue_if;
  logic [19:0] Direction;
  logic        Mem_rd;
  logic        Mem_ack;
  logic [7:0]  Bus;

  modport master (output Direction, Mem_rd, input Mem_ack, Bus);
  modport slave  (input Direction, Mem_rd, output Mem_ack, Bus);
endinterface

// File: rtl/prefetch_queue_storage.sv
// pq_storage: 4x8 circular byte buffer with head/tail pointers and a
// 4-byte little-endian window starting at the head. Lanes at or beyond
// the valid count read as zero.
module pq_storage
  import pkg_8088::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic [PQ_PW-1:0] adv,       // head advance, taken mod depth
  input  logic [2:0]       count,
  output logic [31:0]      window
);

  logic [PQ_DEPTH-1:0][7:0] mem;
  logic [PQ_PW-1:0]         head, tail;

  // Pointers: reset and flush both empty the buffer.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      head <= head + adv;
    end
  end

  // Byte array: contents beyond count are masked, so no reset needed.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push) mem[tail] <= push_data;
  end

  for (genvar i = 0; i < PQ_DEPTH; i++) begin : g_lane
    logic [PQ_PW-1:0] idx;
    assign idx = head + PQ_PW'(i);
    assign window[8*i +: 8] = (3'(i) < count) ? mem[idx] : 8'h00;
  end

endmodule

// File: rtl/prefetch_queue.sv
// prefetch_queue: 4-byte instruction prefetch queue with a
// IDLE/FETCH/HOLD fetch FSM, fetch and instruction IP counters.
// Optional feature macro PQ_POP_CHECK_EN: adds Pop_err and ignores
// over-long pops instead of clamping them to Count.
module prefetch_queue
  import pkg_8088::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             CS,
  input  logic [15:0]             New_IP,
  input  logic                    Flush,
  input  logic [2:0]              Pop,
  output logic [31:0]             Instruction,
  output logic [2:0]              Count,
  output logic [15:0]             Inst_IP,
  prefetch_queue_if.master        mem
`ifdef PQ_POP_CHECK_EN
  ,
  output logic                    Pop_err
`endif
);

  pq_state_t   state, state_nxt;
  logic [15:0] fetch_ip;
  logic [2:0]  pop_eff;
  logic [2:0]  count_nxt;
  logic        ack_take;
`ifdef PQ_POP_CHECK_EN
  logic        pop_bad;
`endif

  // Effective pop: a request larger than the queue is either dropped
  // (and flagged) or trimmed to what is actually there.
  always_comb begin
    pop_eff = Pop;
`ifdef PQ_POP_CHECK_EN
    pop_bad = 1'b0;
    if (Pop > Count) begin
      pop_eff = 3'd0;
      pop_bad = 1'b1;
    end
`else
    if (Pop > Count) pop_eff = Count;
`endif
  end

  // Ack only counts while the request is actually out.
  assign ack_take  = (state == FETCH) && mem.Mem_ack;
  assign count_nxt = Count - pop_eff + {2'b00, ack_take};

  // Next fetch state; Flush always parks the FSM in HOLD for a cycle.
  always_comb begin
    state_nxt = state;
    if (Flush) begin
      state_nxt = HOLD;
    end else begin
      case (state)
        IDLE:    if (count_nxt < 3'(PQ_DEPTH)) state_nxt = FETCH;
        FETCH:   if (ack_take && count_nxt == 3'(PQ_DEPTH)) state_nxt = IDLE;
        HOLD:    state_nxt = FETCH;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Occupancy and IP counters; Flush overrides any pop/ack this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      Count    <= 3'd0;
      Inst_IP  <= 16'h0000;
      fetch_ip <= 16'h0000;
    end else if (Flush) begin
      Count    <= 3'd0;
      Inst_IP  <= New_IP;
      fetch_ip <= New_IP;
    end else begin
      Count   <= count_nxt;
      Inst_IP <= Inst_IP + {13'd0, pop_eff};
      if (ack_take) fetch_ip <= fetch_ip + 16'd1;
    end
  end

`ifdef PQ_POP_CHECK_EN
  // One-cycle error pulse for a rejected pop.
  always_ff @(posedge clk) begin
    if (reset) Pop_err <= 1'b0;
    else       Pop_err <= pop_bad && !Flush;
  end
`endif

  assign mem.Mem_rd    = (state == FETCH);
  assign mem.Direction = phys_addr(CS, fetch_ip);

  pq_storage u_storage (
    .clk       (clk),
    .reset     (reset),
    .flush     (Flush),
    .push      (ack_take),
    .push_data (mem.Bus),
    .adv       (pop_eff[PQ_PW-1:0]),
    .count     (Count),
    .window    (Instruction)
  );

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: a directed vector table for the named
// scenarios, a HOLD-restart sequence, then randomized traffic against a
// byte-queue reference model. Honors PQ_POP_CHECK_EN.
module tb_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] CS, New_IP;
  logic        Flush;
  logic [2:0]  Pop;
  logic [31:0] Instruction;
  logic [2:0]  Count;
  logic [15:0] Inst_IP;
`ifdef PQ_POP_CHECK_EN
  logic        Pop_err;
`endif

  prefetch_queue_if mif();

  always #5 clk = ~clk;

  prefetch_queue dut (
    .clk(clk), .reset(reset), .CS(CS), .New_IP(New_IP), .Flush(Flush),
    .Pop(Pop), .Instruction(Instruction), .Count(Count), .Inst_IP(Inst_IP),
    .mem(mif)
`ifdef PQ_POP_CHECK_EN
    , .Pop_err(Pop_err)
`endif
  );

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic cyc(input bit rst, input bit fl, input logic [15:0] nip,
                     input logic [2:0] pop, input bit ack, input logic [7:0] bus);
    reset = rst; Flush = fl; New_IP = nip; Pop = pop;
    mif.Mem_ack = ack; mif.Bus = bus;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mq[$];
  logic [15:0] m_iip, m_fip;
  bit          m_rd, m_hold, m_err;

  task automatic model_edge(input bit rst, input bit fl, input logic [15:0] nip,
                            input logic [2:0] pop, input bit ack, input logic [7:0] bus);
    int pe;
    bit take;
    if (rst) begin
      mq.delete(); m_iip = 0; m_fip = 0; m_rd = 0; m_hold = 0; m_err = 0;
    end else if (fl) begin
      mq.delete(); m_iip = nip; m_fip = nip; m_rd = 0; m_hold = 1; m_err = 0;
    end else begin
      take  = m_rd && ack;
      pe    = int'(pop);
      m_err = 0;
`ifdef PQ_POP_CHECK_EN
      if (pe > mq.size()) begin pe = 0; m_err = 1; end
`else
      if (pe > mq.size()) pe = mq.size();
`endif
      repeat (pe) void'(mq.pop_front());
      m_iip = m_iip + 16'(pe);
      if (take) begin mq.push_back(bus); m_fip = m_fip + 16'd1; end
      if (m_hold) begin m_hold = 0; m_rd = 1; end
      else if (m_rd) begin if (take && mq.size() == 4) m_rd = 0; end
      else m_rd = (mq.size() < 4);
    end
  endtask

  function automatic logic [31:0] exp_instr();
    logic [31:0] r = 32'h0;
    for (int i = 0; i < mq.size(); i++) r[8*i +: 8] = mq[i];
    return r;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct packed {
    bit          rst, fl;
    logic [15:0] nip;
    logic [2:0]  pop;
    bit          ack;
    logic [7:0]  bus;
    logic [2:0]  e_cnt;
    bit          e_rd;
    logic [19:0] e_dir;
    bit          c_dir;
    logic [15:0] e_iip;
    logic [31:0] e_ins;
    bit          e_err;
  } vec_t;

  vec_t tv[22];

  function automatic vec_t mk(bit rst, bit fl, logic [15:0] nip, logic [2:0] pop,
                              bit ack, logic [7:0] bus, logic [2:0] cnt, bit rd,
                              logic [19:0] dir, bit cdir, logic [15:0] iip,
                              logic [31:0] ins, bit err);
    vec_t v;
    v.rst = rst; v.fl = fl; v.nip = nip; v.pop = pop; v.ack = ack; v.bus = bus;
    v.e_cnt = cnt; v.e_rd = rd; v.e_dir = dir; v.c_dir = cdir; v.e_iip = iip;
    v.e_ins = ins; v.e_err = err;
    return v;
  endfunction

  logic [19:0] edir;
  string       nm;

  initial begin
    CS = 16'h1000; reset = 1; Flush = 0; New_IP = 0; Pop = 0;
    mif.Mem_ack = 0; mif.Bus = 0;

    // fill four bytes, memory acks one cycle after each request
    tv[0]  = mk(1,0,16'h0,0,0,8'h00, 0,0,20'h0,    0,16'h0,   32'h0,0);
    tv[1]  = mk(0,0,16'h0,0,0,8'h00, 0,1,20'h10000,1,16'h0,   32'h0,0);
    tv[2]  = mk(0,0,16'h0,0,0,8'h00, 0,1,20'h10000,1,16'h0,   32'h0,0);
    tv[3]  = mk(0,0,16'h0,0,1,8'h11, 1,1,20'h10001,1,16'h0,   32'h00000011,0);
    tv[4]  = mk(0,0,16'h0,0,0,8'h00, 1,1,20'h10001,1,16'h0,   32'h00000011,0);
    tv[5]  = mk(0,0,16'h0,0,1,8'h22, 2,1,20'h10002,1,16'h0,   32'h00002211,0);
    tv[6]  = mk(0,0,16'h0,0,0,8'h00, 2,1,20'h10002,1,16'h0,   32'h00002211,0);
    tv[7]  = mk(0,0,16'h0,0,1,8'h33, 3,1,20'h10003,1,16'h0,   32'h00332211,0);
    tv[8]  = mk(0,0,16'h0,0,0,8'h00, 3,1,20'h10003,1,16'h0,   32'h00332211,0);
    tv[9]  = mk(0,0,16'h0,0,1,8'h44, 4,0,20'h0,    0,16'h0,   32'h44332211,0);
    tv[10] = mk(0,0,16'h0,0,0,8'h00, 4,0,20'h0,    0,16'h0,   32'h44332211,0);
    // pop two from a full queue, fetch resumes at 0x10004
    tv[11] = mk(0,0,16'h0,2,0,8'h00, 2,1,20'h10004,1,16'h0002,32'h00004433,0);
    tv[12] = mk(0,0,16'h0,0,0,8'h00, 2,1,20'h10004,1,16'h0002,32'h00004433,0);
    tv[13] = mk(0,0,16'h0,0,1,8'h55, 3,1,20'h10005,1,16'h0002,32'h00554433,0);
    // pop one with a concurrent ack at Count=3
    tv[14] = mk(0,0,16'h0,1,1,8'h66, 3,1,20'h10006,1,16'h0003,32'h00665544,0);
    // flush to 0xFFFF with a concurrent ack, then segment wrap
    tv[15] = mk(0,1,16'hFFFF,0,1,8'h99, 0,0,20'h0, 0,16'hFFFF,32'h0,0);
    tv[16] = mk(0,0,16'h0,0,0,8'h00, 0,1,20'h1FFFF,1,16'hFFFF,32'h0,0);
    tv[17] = mk(0,0,16'h0,0,1,8'h77, 1,1,20'h10000,1,16'hFFFF,32'h00000077,0);
    // over-long pop at Count=1
`ifdef PQ_POP_CHECK_EN
    tv[18] = mk(0,0,16'h0,3,0,8'h00, 1,1,20'h10000,1,16'hFFFF,32'h00000077,1);
    tv[19] = mk(0,0,16'h0,0,0,8'h00, 1,1,20'h10000,1,16'hFFFF,32'h00000077,0);
`else
    tv[18] = mk(0,0,16'h0,3,0,8'h00, 0,1,20'h10000,1,16'h0000,32'h0,0);
    tv[19] = mk(0,0,16'h0,0,0,8'h00, 0,1,20'h10000,1,16'h0000,32'h0,0);
`endif
    // reset while fetching, ack in the reset cycle is lost
    tv[20] = mk(1,0,16'h0,0,1,8'hAA, 0,0,20'h0,    0,16'h0,   32'h0,0);
    tv[21] = mk(0,0,16'h0,0,1,8'hBB, 0,1,20'h10000,1,16'h0,   32'h0,0);

    for (int i = 0; i < 22; i++) begin
      cyc(tv[i].rst, tv[i].fl, tv[i].nip, tv[i].pop, tv[i].ack, tv[i].bus);
      check($sformatf("row%0d count", i), 32'(Count), 32'(tv[i].e_cnt));
      check($sformatf("row%0d mem_rd", i), 32'(mif.Mem_rd), 32'(tv[i].e_rd));
      check($sformatf("row%0d inst_ip", i), 32'(Inst_IP), 32'(tv[i].e_iip));
      check($sformatf("row%0d instr", i), Instruction, tv[i].e_ins);
      if (tv[i].c_dir)
        check($sformatf("row%0d dir", i), 32'(mif.Direction), 32'(tv[i].e_dir));
`ifdef PQ_POP_CHECK_EN
      check($sformatf("row%0d pop_err", i), 32'(Pop_err), 32'(tv[i].e_err));
`endif
    end

    // Flush again while in HOLD: the later New_IP wins.
    cyc(0,1,16'h1234,0,0,8'h00);
    check("hold1 mem_rd", 32'(mif.Mem_rd), 32'd0);
    cyc(0,1,16'h2000,0,1,8'h00);
    check("hold2 mem_rd", 32'(mif.Mem_rd), 32'd0);
    check("hold2 inst_ip", 32'(Inst_IP), 32'h2000);
    cyc(0,0,16'h0,0,1,8'h00);
    check("hold3 mem_rd", 32'(mif.Mem_rd), 32'd1);
    check("hold3 dir", 32'(mif.Direction), 32'h12000);
    check("hold3 count", 32'(Count), 32'd0);

    // Randomized traffic against the reference model.
    CS = 16'hF123;
    cyc(1,0,16'h0,0,0,8'h00);
    model_edge(1,0,16'h0,0,0,8'h00);
    for (int n = 0; n < 800; n++) begin
      bit          r_rst, r_fl, r_ack;
      logic [15:0] r_nip;
      logic [2:0]  r_pop;
      logic [7:0]  r_bus;
      r_rst = ($urandom_range(0, 79) == 0);
      r_fl  = ($urandom_range(0, 19) == 0);
      r_nip = ($urandom_range(0, 2) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3))
                                          : 16'($urandom);
      r_pop = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 4)) : 3'd0;
      r_ack = 1'($urandom_range(0, 1));
      r_bus = 8'($urandom);
      model_edge(r_rst, r_fl, r_nip, r_pop, r_ack, r_bus);
      cyc(r_rst, r_fl, r_nip, r_pop, r_ack, r_bus);
      nm = $sformatf("rnd%0d", n);
      check({nm, " count"}, 32'(Count), 32'(mq.size()));
      check({nm, " inst_ip"}, 32'(Inst_IP), 32'(m_iip));
      check({nm, " mem_rd"}, 32'(mif.Mem_rd), 32'(m_rd));
      check({nm, " instr"}, Instruction, exp_instr());
      if (m_rd) begin
        edir = {CS, 4'h0} + {4'h0, m_fip};
        check({nm, " dir"}, 32'(mif.Direction), 32'(edir));
      end
`ifdef PQ_POP_CHECK_EN
      check({nm, " pop_err"}, 32'(Pop_err), 32'(m_err));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock, rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous reset, active-high.
REQ-003 The block SHALL have the port CS, input, 16 bits: code segment base.
REQ-004 The block SHALL have the port New_IP, input, 16 bits: restart offset, sampled when Flush=1.
REQ-005 The block SHALL have the port Flush, input, 1 bit: discard the queue and restart fetching at New_IP.
REQ-006 The block SHALL have the port Direction, output, 20 bits: physical fetch address.
REQ-007 The block SHALL have the port Mem_rd, output, 1 bit: fetch request, held until Mem_ack.
REQ-008 The block SHALL have the port Mem_ack, input, 1 bit: Bus holds valid data; sampled only while Mem_rd=1.
REQ-009 The block SHALL have the port Bus, input, 8 bits: fetched byte.
REQ-010 The block SHALL have the port Pop, input, 3 bits: number of bytes the decoder consumes this cycle (0-4).
REQ-011 The block SHALL have the port Instruction, output, 32 bits: head bytes, little-endian (byte0 in [7:0]).
REQ-012 The block SHALL have the port Count, output, 3 bits: valid bytes in the queue (0-4).
REQ-013 The block SHALL have the port Inst_IP, output, 16 bits: offset of the byte in Instruction[7:0].

Function
REQ-014 Queue depth SHALL be 4 bytes; Instruction byte lanes at index >= Count SHALL read 8'h00.
REQ-015 Direction SHALL equal ({CS,4'h0} + fetch_IP) mod 2^20; fetch_IP SHALL wrap 16'hFFFF->16'h0000 inside the segment.
REQ-016 Fetch FSM states SHALL be IDLE, FETCH and HOLD.
REQ-017 IDLE->FETCH SHALL occur when Count-after-update < 4 and Flush=0; in FETCH, Mem_rd=1 and Direction stays stable until Mem_ack.
REQ-018 On Mem_ack in FETCH, Bus SHALL be written at the tail and fetch_IP incremented; the FSM SHALL stay in FETCH if the queue is still not full, else go to IDLE.
REQ-019 A Pop and a Mem_ack in the same cycle SHALL both take effect: Count' = Count - Pop + 1.
REQ-020 A Pop SHALL advance the head by Pop bytes and add Pop to Inst_IP (16-bit wrap); all outputs SHALL update on the next edge.
REQ-021 Flush SHALL win over Pop and Mem_ack in the same cycle: Count'=0, Inst_IP'=fetch_IP'=New_IP, and any ack that cycle is discarded.
REQ-022 After a Flush the FSM SHALL enter HOLD for exactly one cycle with Mem_rd=0, then FETCH at the new address.
REQ-023 A Flush asserted while in HOLD SHALL restart HOLD with the latest New_IP.
REQ-024 Mem_ack SHALL be ignored when Mem_rd=0.

Reset
REQ-025 When reset=1 at a rising edge: Count=0, Inst_IP=0, fetch_IP=0, FSM=IDLE, Mem_rd=0, Instruction=0, and Pop_err=0 when present.
REQ-026 Reset mid-fetch SHALL drop Mem_rd on the next cycle; a Mem_ack in the reset cycle SHALL be discarded.
REQ-027 Reset SHALL dominate Flush.

Configuration
REQ-028 With macro PQ_POP_CHECK_EN defined, the block SHALL add output Pop_err (1 bit), and a Pop > Count SHALL be ignored entirely (a concurrent Mem_ack is still accepted) with Pop_err pulsing high for one cycle.
REQ-029 With PQ_POP_CHECK_EN undefined, the block SHALL have no Pop_err port and SHALL clamp the effective Pop to Count.

Structure
REQ-030 The shared package pkg_8088 SHALL hold the FSM state enum (IDLE/FETCH/HOLD), the constant PQ_DEPTH=4 and a physical-address function (segment, offset)->20 bits.
REQ-031 The byte storage (4x8 circular buffer, head/tail pointers, 4-byte head window) SHALL be the sub-module pq_storage; the FSM and the IP counters SHALL stay in prefetch_queue.

Verification
REQ-032 The bench SHALL cover reset then CS=16'h1000, memory acking 1 cycle after Mem_rd: Direction=20'h10000,10001,10002,10003; Count reaches 4; Mem_rd=0; Instruction equals the 4 bytes.
REQ-033 The bench SHALL cover a full queue with Pop=2: the next cycle gives Count=2, Inst_IP=16'h0002, Instruction[15:0] equal to the old bytes 2-3, upper lanes 0, and FETCH resumes at 20'h10004.
REQ-034 The bench SHALL cover Flush with New_IP=16'hFFFF in the same cycle as Mem_ack: the ack is discarded, Count=0, Mem_rd=0 for one cycle, then Direction=20'h1FFFF followed by 20'h10000 (wrap).
REQ-035 The bench SHALL cover Count=3 with Pop=1 and Mem_ack in the same cycle: Count stays 3 and Inst_IP increments by 1.
REQ-036 The bench SHALL cover Count=1, Pop=3: with PQ_POP_CHECK_EN, Pop_err=1 for one cycle and Count=1; without it, Count=0 and Inst_IP advances by 1.
REQ-037 The bench SHALL cover reset asserted while Mem_rd=1: Mem_rd=0 on the next cycle, Count=0, and an ack in the reset cycle leaves no byte in the queue.
